imem_uart_loader: RTL
=====================

// Module: imem_uart_loader
// PURPOSE
//  Serial boot loader writing the instruction RAM that the pipelined SIMPLE core fetches from.
//  Contains a UART receiver (8N1) and a frame-parsing FSM that writes one 16-bit word per RAM write.
//  Holds the core stalled via cpu_run=0 until a frame is loaded and its checksum passes.
//  Sits between the board RXD pin and the write port of the instruction RAM.
// PARAMETERS
//  CLKS_PER_BIT  434     clk cycles per UART bit (50 MHz / 115200); must be >= 4
//  ADDR_W        16      instruction RAM address width
//  BASE_ADDR     16'h0   address written by the first data word
// PORTS
//  clk           in   1       system clock, all state on posedge
//  rst_n         in   1       reset, asynchronous, active-low
//  rxd           in   1       UART serial input, idle high, asynchronous to clk
//  load_req      in   1       one-cycle pulse: abort/restart load, drop cpu_run
//  ram_addr      out  ADDR_W  instruction RAM write address
//  ram_data      out  16      instruction RAM write data
//  ram_wren      out  1       RAM write enable, one clk per word
//  cpu_run       out  1       1 = core may execute (gate into core clock enable)
//  busy          out  1       1 = frame in progress (after sync byte, before checksum)
//  err           out  1       sticky: checksum or framing error on the last attempt
//  words_loaded  out  16      data words written in the current/last frame
// BEHAVIOUR
//  Reset: ram_addr=BASE_ADDR, ram_data=0, ram_wren=0, cpu_run=0, busy=0, err=0, words_loaded=0.
//    FSM enters WAIT_SYNC; the UART receiver is idle.
//  UART RX:
//    - rxd passes through a 2-FF synchroniser.
//    - A falling edge starts a bit counter. The start bit is re-sampled at CLKS_PER_BIT/2 and must
//      still be 0, otherwise the receiver returns to idle silently.
//    - Then 8 data bits, LSB first, each sampled mid-bit.
//    - Stop bit sampled mid-bit:
//        1 -> byte_valid pulses for one clk;
//        0 -> framing error, byte discarded, frame_err pulses for one clk.
//  Frame: 0x55, N_hi, N_lo, N data words (each MSB byte first), CHK.
//    CHK = mod-256 sum of every byte after 0x55 except CHK itself.
//  FSM states (advance only on byte_valid unless noted):
//    WAIT_SYNC -> CNT_HI when byte==0x55; any other byte is ignored.
//                 Entering CNT_HI clears err and words_loaded, sets busy=1, sets sum=0.
//    CNT_HI    -> CNT_LO.
//    CNT_LO    -> DATA_HI if N!=0, else CHECK.
//    DATA_HI   -> DATA_LO; latches the high byte.
//    DATA_LO   -> WRITE.
//    WRITE     (1 clk, no byte needed) -> DATA_HI if more words remain, else CHECK.
//    CHECK     on CHK byte -> DONE if CHK==sum; else err=1 and -> WAIT_SYNC. busy=0 in both cases.
//    DONE      cpu_run=1; further bytes are ignored.
//  Write timing:
//    - The clk after the DATA_LO byte_valid, ram_wren=1 for exactly one clk.
//    - ram_addr=BASE_ADDR+index and ram_data={hi,lo} are registered and held stable through that
//      cycle (the RAM samples on the falling edge).
//    - index and words_loaded increment at the end of WRITE.
//    - ram_addr wraps modulo 2^ADDR_W.
//  sum accumulates N_hi, N_lo and every data byte, mod 256.
//  A bad checksum does not roll back RAM contents already written; cpu_run stays 0.
//  frame_err in any state except WAIT_SYNC and DONE: err=1, busy=0, -> WAIT_SYNC.
//  load_req: from any state, next clk cpu_run=0, busy=0, index reset, -> WAIT_SYNC.
//    err and words_loaded are held.
//    load_req beats a byte_valid arriving in the same cycle; that byte is dropped.
//    The UART receiver itself is not reset by load_req.
//  rst_n asserted mid-frame: immediate return to reset values; ram_wren is never asserted while
//    rst_n=0.
// TESTING  (CLKS_PER_BIT=4, BASE_ADDR=0)
//  1. Send 55 00 02 12 34 AB CD C0 -> writes (0x0000,0x1234), (0x0001,0xABCD), each a 1-clk
//     ram_wren; then cpu_run=1, words_loaded=2, err=0.
//  2. Same frame with CHK=C1 -> both words written; err=1, cpu_run=0, busy=0, FSM in WAIT_SYNC.
//  3. Send 00 FF 55 00 00 00 -> leading bytes ignored, no ram_wren, cpu_run=1, words_loaded=0.
//  4. Send 55 00 01 12, then a byte whose stop bit is 0 -> err=1, no write; a following good
//     frame clears err and loads.
//  5. In DONE, pulse load_req in the same cycle as byte_valid -> cpu_run=0 next clk; byte dropped;
//     a new frame loads from address 0.
//  6. Assert rst_n low during DATA_LO of word 1 -> all outputs at reset values; no ram_wren until
//     a new complete word.

Source files
------------

// File: rtl/imem_uart_loader.sv
// Serial boot loader: 8N1 UART receiver feeding a frame parser that writes 16-bit words
// into the instruction RAM and releases the core once the frame checksum matches.
module imem_uart_loader #(
   parameter int                CLKS_PER_BIT = 434,
   parameter int                ADDR_W       = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR    = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rxd,
   input  logic              load_req,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [15:0]       ram_data,
   output logic              ram_wren,
   output logic              cpu_run,
   output logic              busy,
   output logic              err,
   output logic [15:0]       words_loaded
);
   localparam int CW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {
      S_WAIT_SYNC, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CHECK, S_DONE
   } ld_state_t;

   rx_state_t   r_rx_state;
   logic        r_rx_s1, r_rx_s2, r_rx_prev;
   logic [CW-1:0] r_clk_cnt;
   logic [2:0]  r_bit_idx;
   logic [7:0]  r_shift;
   logic [7:0]  r_byte;
   logic        r_byte_vld;
   logic        r_frame_err;

   ld_state_t   r_state;
   logic [15:0] r_cnt;
   logic [15:0] r_index;
   logic [7:0]  r_hi;
   logic [7:0]  r_sum;

   logic              w_rx_fall;
   logic [7:0]        w_sum_next;
   logic [ADDR_W-1:0] w_wr_addr;

   assign w_rx_fall  = r_rx_prev & ~r_rx_s2;
   assign w_sum_next = r_sum + r_byte;
   assign w_wr_addr  = BASE_ADDR + ADDR_W'(r_index);

   // UART receiver; every sample point lands mid-bit counted from the synchronised falling edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_s1     <= 1'b1;
         r_rx_s2     <= 1'b1;
         r_rx_prev   <= 1'b1;
         r_rx_state  <= RX_IDLE;
         r_clk_cnt   <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_byte      <= '0;
         r_byte_vld  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_s1     <= rxd;
         r_rx_s2     <= r_rx_s1;
         r_rx_prev   <= r_rx_s2;
         r_byte_vld  <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_rx_state)
            RX_IDLE: begin
               r_clk_cnt <= '0;
               r_bit_idx <= '0;
               if (w_rx_fall) r_rx_state <= RX_START;
            end
            RX_START: begin
               if (r_clk_cnt == CW'(CLKS_PER_BIT/2 - 1)) begin
                  r_clk_cnt  <= '0;
                  r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (r_clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                  r_clk_cnt <= '0;
                  r_shift   <= {r_rx_s2, r_shift[7:1]};
                  if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
                  else                   r_bit_idx  <= r_bit_idx + 1'b1;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (r_clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                  r_clk_cnt  <= '0;
                  r_rx_state <= RX_IDLE;
                  if (r_rx_s2) begin
                     r_byte     <= r_shift;
                     r_byte_vld <= 1'b1;
                  end else begin
                     r_frame_err <= 1'b1;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end

   // Frame parser; load_req outranks everything, including a byte arriving in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_WAIT_SYNC;
         r_cnt        <= '0;
         r_index      <= '0;
         r_hi         <= '0;
         r_sum        <= '0;
         ram_addr     <= BASE_ADDR;
         ram_data     <= '0;
         ram_wren     <= 1'b0;
         cpu_run      <= 1'b0;
         busy         <= 1'b0;
         err          <= 1'b0;
         words_loaded <= '0;
      end else begin
         ram_wren <= 1'b0;
         if (load_req) begin
            r_state <= S_WAIT_SYNC;
            cpu_run <= 1'b0;
            busy    <= 1'b0;
            r_index <= '0;
         end else if (r_frame_err && r_state != S_WAIT_SYNC && r_state != S_DONE) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_WAIT_SYNC;
         end else begin
            case (r_state)
               S_WAIT_SYNC: if (r_byte_vld && r_byte == 8'h55) begin
                  r_state      <= S_CNT_HI;
                  err          <= 1'b0;
                  words_loaded <= '0;
                  busy         <= 1'b1;
                  r_sum        <= '0;
                  r_index      <= '0;
               end
               S_CNT_HI: if (r_byte_vld) begin
                  r_cnt[15:8] <= r_byte;
                  r_sum       <= w_sum_next;
                  r_state     <= S_CNT_LO;
               end
               S_CNT_LO: if (r_byte_vld) begin
                  r_cnt[7:0] <= r_byte;
                  r_sum      <= w_sum_next;
                  r_state    <= ({r_cnt[15:8], r_byte} != 16'd0) ? S_DATA_HI : S_CHECK;
               end
               S_DATA_HI: if (r_byte_vld) begin
                  r_hi    <= r_byte;
                  r_sum   <= w_sum_next;
                  r_state <= S_DATA_LO;
               end
               S_DATA_LO: if (r_byte_vld) begin
                  r_sum    <= w_sum_next;
                  ram_addr <= w_wr_addr;
                  ram_data <= {r_hi, r_byte};
                  ram_wren <= 1'b1;
                  r_state  <= S_WRITE;
               end
               S_WRITE: begin
                  r_index      <= r_index + 16'd1;
                  words_loaded <= words_loaded + 16'd1;
                  r_state      <= (r_index + 16'd1 != r_cnt) ? S_DATA_HI : S_CHECK;
               end
               S_CHECK: if (r_byte_vld) begin
                  busy <= 1'b0;
                  if (r_byte == r_sum) begin
                     cpu_run <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     err     <= 1'b1;
                     r_state <= S_WAIT_SYNC;
                  end
               end
               S_DONE: ;
               default: r_state <= S_WAIT_SYNC;
            endcase
         end
      end
   end
endmodule
